// File: rtl/multicycle_sequencer.sv
// Multi-cycle LEGv8 control sequencer: FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK with
// variable-latency memory handshakes, retire counting and halt/timeout detection.
module multicycle_sequencer #(
    parameter int WAIT_LIMIT = 15,
    parameter int CNT_W      = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [31:0]      Instruction,
    input  logic [8:0]       ControlIn,
    input  logic             Zero,
    input  logic             imem_ready,
    input  logic             dmem_ready,
    output logic             imem_req,
    output logic             dmem_req,
    output logic             IRWrite,
    output logic             PCWrite,
    output logic             PCSrc,
    output logic             MemReadEn,
    output logic             MemWriteEn,
    output logic             RegWriteEn,
    output logic [8:0]       ControlOut,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] retired,
    output logic             halted,
    output logic             fault
);
    typedef enum logic [2:0] {
        S_FETCH     = 3'd0,
        S_DECODE    = 3'd1,
        S_EXECUTE   = 3'd2,
        S_MEMORY    = 3'd3,
        S_WRITEBACK = 3'd4,
        S_HALT      = 3'd5,
        S_FAULT     = 3'd6
    } state_t;

    localparam logic [7:0] LIMIT = 8'(WAIT_LIMIT);

    state_t     cur, nxt;
    logic [8:0] ctrl_q, ctrl_d;
    logic [7:0] wait_cnt, wait_d;
    logic       retire;
    logic       ireq, dreq, irw, pcw, pcs, mre, mwe, rwe;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cur      <= S_FETCH;
            ctrl_q   <= '0;
            wait_cnt <= '0;
            retired  <= '0;
        end else begin
            cur      <= nxt;
            ctrl_q   <= ctrl_d;
            wait_cnt <= wait_d;
            if (retire)
                retired <= retired + CNT_W'(1);
        end
    end

    always_comb begin
        nxt    = cur;
        ctrl_d = ctrl_q;
        wait_d = '0;
        retire = 1'b0;
        ireq   = 1'b0;
        dreq   = 1'b0;
        irw    = 1'b0;
        pcw    = 1'b0;
        pcs    = 1'b0;
        mre    = 1'b0;
        mwe    = 1'b0;
        rwe    = 1'b0;
        case (cur)
            S_FETCH: begin
                ireq = 1'b1;
                if (imem_ready) begin
                    irw = 1'b1;
                    nxt = S_DECODE;
                end else begin
                    wait_d = wait_cnt + 8'd1;
                    if (wait_cnt == LIMIT)
                        nxt = S_FAULT;
                end
            end
            S_DECODE: begin
                ctrl_d = ControlIn;
                nxt    = (Instruction == 32'h0) ? S_HALT : S_EXECUTE;
            end
            S_EXECUTE: begin
                // Branch outranks the memory and register-write bits.
                if (ctrl_q[2]) begin
                    pcw    = 1'b1;
                    pcs    = Zero;
                    retire = 1'b1;
                    nxt    = S_FETCH;
                end else if (ctrl_q[4] || ctrl_q[3]) begin
                    nxt = S_MEMORY;
                end else if (ctrl_q[5]) begin
                    nxt = S_WRITEBACK;
                end else begin
                    pcw    = 1'b1;
                    retire = 1'b1;
                    nxt    = S_FETCH;
                end
            end
            S_MEMORY: begin
                dreq = 1'b1;
                mre  = ctrl_q[4];
                mwe  = ctrl_q[3];
                if (dmem_ready) begin
                    if (ctrl_q[4]) begin
                        nxt = S_WRITEBACK;
                    end else begin
                        pcw    = 1'b1;
                        retire = 1'b1;
                        nxt    = S_FETCH;
                    end
                end else begin
                    wait_d = wait_cnt + 8'd1;
                    if (wait_cnt == LIMIT)
                        nxt = S_FAULT;
                end
            end
            S_WRITEBACK: begin
                rwe    = 1'b1;
                pcw    = 1'b1;
                retire = 1'b1;
                nxt    = S_FETCH;
            end
            S_HALT:  nxt = S_HALT;
            S_FAULT: nxt = S_FAULT;
            default: nxt = S_FAULT;
        endcase
    end

    // Reset lands in FETCH immediately, so strobes are masked while it is held.
    assign imem_req   = ireq & ~reset;
    assign dmem_req   = dreq & ~reset;
    assign IRWrite    = irw  & ~reset;
    assign PCWrite    = pcw  & ~reset;
    assign PCSrc      = pcs  & ~reset;
    assign MemReadEn  = mre  & ~reset;
    assign MemWriteEn = mwe  & ~reset;
    assign RegWriteEn = rwe  & ~reset;
    assign ControlOut = ctrl_q;
    assign state      = cur;
    assign halted     = (cur == S_HALT);
    assign fault      = (cur == S_FAULT);
endmodule

// File: tb/tb_multicycle_sequencer.sv
// Randomized bench for multicycle_sequencer: a per-instruction reference model expands
// each instruction into expected per-cycle outputs and the ready pattern to drive.
module tb_multicycle_sequencer;
    localparam int LIM = 15;
    localparam int K_ALU = 0, K_LD = 1, K_ST = 2, K_BR = 3, K_NOP = 4;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] Instruction = 32'h1;
    logic [8:0]  ControlIn = '0;
    logic        Zero = 1'b0, imem_ready = 1'b0, dmem_ready = 1'b0;
    logic        imem_req, dmem_req, IRWrite, PCWrite, PCSrc;
    logic        MemReadEn, MemWriteEn, RegWriteEn, halted, fault;
    logic [8:0]  ControlOut;
    logic [2:0]  state;
    logic [31:0] retired;

    always #5 clock = ~clock;

    multicycle_sequencer #(.WAIT_LIMIT(LIM), .CNT_W(32)) dut (
        .clock(clock), .reset(reset), .Instruction(Instruction), .ControlIn(ControlIn),
        .Zero(Zero), .imem_ready(imem_ready), .dmem_ready(dmem_ready),
        .imem_req(imem_req), .dmem_req(dmem_req), .IRWrite(IRWrite), .PCWrite(PCWrite),
        .PCSrc(PCSrc), .MemReadEn(MemReadEn), .MemWriteEn(MemWriteEn),
        .RegWriteEn(RegWriteEn), .ControlOut(ControlOut), .state(state),
        .retired(retired), .halted(halted), .fault(fault)
    );

    // Expected outputs first, then the inputs to apply in that cycle.
    typedef struct packed {
        logic [2:0]  st;
        logic        ireq, dreq, irw, pcw, pcs, mre, mwe, rwe, hlt, flt;
        logic [8:0]  co;
        logic [31:0] ret;
        logic        ir, dr, z;
        logic [31:0] instr;
        logic [8:0]  ctl;
    } cyc_t;

    cyc_t        q[$];
    int unsigned m_ret;
    logic [8:0]  m_ctl;
    logic [2:0]  m_st;
    int          checks = 0, errors = 0;

    function automatic logic [53:0] expv(input cyc_t c);
        return {c.st, c.ireq, c.dreq, c.irw, c.pcw, c.pcs, c.mre, c.mwe, c.rwe,
                c.hlt, c.flt, c.co, c.ret};
    endfunction

    function automatic cyc_t blank(input logic [2:0] st);
        cyc_t c;
        c       = '0;
        c.st    = st;
        c.hlt   = (st == 3'd5);
        c.flt   = (st == 3'd6);
        c.co    = m_ctl;
        c.ret   = m_ret;
        c.ir    = 1'($urandom);
        c.dr    = 1'($urandom);
        c.z     = 1'($urandom);
        c.instr = $urandom | 32'h1;
        c.ctl   = 9'($urandom);
        return c;
    endfunction

    function automatic logic [8:0] make_bundle(input int kind);
        logic [8:0] b;
        b = 9'($urandom);
        case (kind)
            K_ALU:   b[5:2] = 4'b1000;
            K_LD:    b[4:2] = 3'b100;
            K_ST:    b[4:2] = 3'b010;
            K_BR:    b[2]   = 1'b1;
            default: b[5:2] = 4'b0000;
        endcase
        return b;
    endfunction

    // One handshake phase: d ready-low cycles then ready; beyond LIM it times out.
    task automatic m_wait(input logic fetch, input logic is_load, input int d, output logic ok);
        cyc_t c;
        int n;
        n = (d > LIM) ? LIM + 1 : d + 1;
        for (int k = 0; k < n; k++) begin
            c = blank(fetch ? 3'd0 : 3'd3);
            if (fetch) begin
                c.ireq = 1'b1;
                c.ir   = (k == d);
                c.irw  = (k == d);
            end else begin
                c.dreq = 1'b1;
                c.mre  = is_load;
                c.mwe  = !is_load;
                c.dr   = (k == d);
                c.pcw  = (k == d) && !is_load;
            end
            q.push_back(c);
        end
        ok = (d <= LIM);
        if (!ok) m_st = 3'd6;
    endtask

    task automatic m_instr(input int kind, input logic [8:0] b, input logic [31:0] instr,
                           input int di, input int dm, input logic z);
        cyc_t c;
        logic ok;
        m_wait(1'b1, 1'b0, di, ok);
        if (!ok) return;
        c = blank(3'd1); c.ctl = b; c.instr = instr; q.push_back(c);
        m_ctl = b;
        if (instr == 32'h0) begin m_st = 3'd5; return; end
        c = blank(3'd2); c.z = z;
        if (kind == K_BR || kind == K_NOP) begin
            c.pcw = 1'b1;
            c.pcs = (kind == K_BR) ? z : 1'b0;
            q.push_back(c);
            m_ret++;
            return;
        end
        q.push_back(c);
        if (kind == K_LD || kind == K_ST) begin
            m_wait(1'b0, kind == K_LD, dm, ok);
            if (!ok) return;
            if (kind == K_ST) begin m_ret++; return; end
        end
        c = blank(3'd4); c.rwe = 1'b1; c.pcw = 1'b1; q.push_back(c);
        m_ret++;
    endtask

    task automatic m_sticky(input int n);
        for (int k = 0; k < n; k++) q.push_back(blank(m_st));
    endtask

    task automatic drive(input cyc_t c, output logic [53:0] obs);
        @(negedge clock);
        imem_ready = c.ir; dmem_ready = c.dr; Zero = c.z;
        Instruction = c.instr; ControlIn = c.ctl;
        #1;
        obs = {state, imem_req, dmem_req, IRWrite, PCWrite, PCSrc, MemReadEn, MemWriteEn,
               RegWriteEn, halted, fault, ControlOut, retired};
    endtask

    // Asserts reset asynchronously, samples while held, releases just after a rising edge.
    task automatic hold_reset(output logic [53:0] obs);
        imem_ready = 1'b1; dmem_ready = 1'b1;
        reset = 1'b1;
        #1;
        obs = {state, imem_req, dmem_req, IRWrite, PCWrite, PCSrc, MemReadEn, MemWriteEn,
               RegWriteEn, halted, fault, ControlOut, retired};
        @(posedge clock); #1;
        reset = 1'b0; imem_ready = 1'b0; dmem_ready = 1'b0;
        m_ret = 0; m_ctl = '0; m_st = 3'd0;
        q.delete();
    endtask

    task automatic test_reset();
        logic [53:0] obs;
        hold_reset(obs);
        checks++;
        if (obs !== 54'h0) begin
            errors++; $display("FAIL reset: got %h expected %h", obs, 54'h0);
        end
    endtask

    task automatic test_directed();
        logic [53:0] obs; cyc_t c;
        m_instr(K_ALU, 9'b000100010, 32'h8B020020, 0, 0, 1'b0);
        m_instr(K_LD,  9'b011110000, 32'hF8400000 | $urandom_range(1, 255), 0, 2, 1'b0);
        m_instr(K_BR,  9'b100000101, 32'hB4000040, 0, 0, 1'b1);
        m_instr(K_BR,  9'b100000101, 32'hB4000041, 0, 0, 1'b0);
        m_instr(K_ST,  9'b110001000, 32'hF8000000 | $urandom_range(1, 255), 1, 0, 1'b0);
        while (q.size() > 0) begin
            c = q.pop_front(); drive(c, obs); checks++;
            if (obs !== expv(c)) begin
                errors++; $display("FAIL directed st=%0d: got %h expected %h", c.st, obs, expv(c));
            end
        end
    endtask

    task automatic test_random();
        logic [53:0] obs; cyc_t c; int kind, di, dm;
        for (int i = 0; i < 40; i++) begin
            kind = int'($urandom_range(0, 4));
            di = ($urandom_range(0, 7) == 0) ? LIM : int'($urandom_range(0, 3));
            dm = ($urandom_range(0, 7) == 0) ? LIM : int'($urandom_range(0, 3));
            m_instr(kind, make_bundle(kind), $urandom | 32'h1, di, dm, 1'($urandom));
        end
        while (q.size() > 0) begin
            c = q.pop_front(); drive(c, obs); checks++;
            if (obs !== expv(c)) begin
                errors++; $display("FAIL random st=%0d: got %h expected %h", c.st, obs, expv(c));
            end
        end
    endtask

    task automatic test_timeout();
        logic [53:0] obs; cyc_t c;
        for (int pass = 0; pass < 2; pass++) begin
            m_instr(K_NOP, make_bundle(K_NOP), 32'h1, 0, 0, 1'b0);
            if (pass == 0) m_instr(K_ALU, make_bundle(K_ALU), 32'h3, LIM + 1, 0, 1'b0);
            else           m_instr(K_ST, make_bundle(K_ST), 32'h5, 0, LIM + 1, 1'b0);
            m_sticky(6);
            while (q.size() > 0) begin
                c = q.pop_front(); drive(c, obs); checks++;
                if (obs !== expv(c)) begin
                    errors++;
                    $display("FAIL timeout%0d st=%0d: got %h expected %h", pass, c.st, obs, expv(c));
                end
            end
            hold_reset(obs); checks++;
            if (obs !== 54'h0) begin
                errors++; $display("FAIL timeout_reset: got %h expected %h", obs, 54'h0);
            end
        end
    endtask

    task automatic test_halt();
        logic [53:0] obs; cyc_t c;
        m_instr(K_ALU, make_bundle(K_ALU), 32'h8B020020, 0, 0, 1'b0);
        m_instr(K_ALU, make_bundle(K_ALU), 32'h0, 1, 0, 1'b0);
        m_sticky(4);
        while (q.size() > 0) begin
            c = q.pop_front(); drive(c, obs); checks++;
            if (obs !== expv(c)) begin
                errors++; $display("FAIL halt st=%0d: got %h expected %h", c.st, obs, expv(c));
            end
        end
        hold_reset(obs); checks++;
        if (obs !== 54'h0) begin
            errors++; $display("FAIL halt_reset: got %h expected %h", obs, 54'h0);
        end
    endtask

    task automatic test_mem_reset();
        logic [53:0] obs; cyc_t c;
        m_instr(K_NOP, make_bundle(K_NOP), 32'h7, 0, 0, 1'b0);
        m_instr(K_ST, make_bundle(K_ST), 32'h9, 0, 5, 1'b0);
        // NOP (3 cycles) + FETCH, DECODE, EXECUTE, two MEMORY wait cycles
        for (int k = 0; k < 8; k++) begin
            c = q.pop_front(); drive(c, obs); checks++;
            if (obs !== expv(c)) begin
                errors++; $display("FAIL mem_reset st=%0d: got %h expected %h", c.st, obs, expv(c));
            end
        end
        hold_reset(obs); checks++;
        if (obs !== 54'h0) begin
            errors++; $display("FAIL mem_reset_async: got %h expected %h", obs, 54'h0);
        end
        m_instr(K_ALU, make_bundle(K_ALU), 32'h8B020020, 0, 0, 1'b0);
        while (q.size() > 0) begin
            c = q.pop_front(); drive(c, obs); checks++;
            if (obs !== expv(c)) begin
                errors++; $display("FAIL mem_reset_after st=%0d: got %h expected %h", c.st, obs, expv(c));
            end
        end
    endtask

    initial begin
        m_ret = 0; m_ctl = '0; m_st = 3'd0;
        test_reset();
        test_directed();
        test_random();
        test_timeout();
        test_halt();
        test_mem_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: run did not complete");
        $fatal(1);
    end
endmodule
